// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The checksum state values exist in every build; only LOAD_CHECKSUM_EN builds reach them.
package inst_mem_loader_pkg;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        CSUM,
        RUN,
        ERR
    } ld_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int          CSUM_W   = 8;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Fetch port (core side) and byte-serial loader port (bridge side) of the instruction memory.
// master drives requests and loader bytes; slave is the memory/loader block.
interface inst_mem_loader_if;

    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        ld_valid_i;
    logic [7:0]  ld_data_i;
    logic        ld_ready_o;
    logic        ld_restart_i;

    modport master (
        output rom_ce_i, rom_addr_i, ld_valid_i, ld_data_i, ld_restart_i,
        input  rom_data_o, ld_ready_o
    );

    modport slave (
        input  rom_ce_i, rom_addr_i, ld_valid_i, ld_data_i, ld_restart_i,
        output rom_data_o, ld_ready_o
    );

endinterface

// File: rtl/inst_mem_ram.sv
// 2**ADDR_W x 32 instruction storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module inst_mem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory with a byte-serial image loader; holds the core in reset until an image is loaded.
// Build option: define LOAD_CHECKSUM_EN to require a trailing checksum byte (CSUM/ERR states, err_o).
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_INST = inst_mem_loader_pkg::NOP_INST
) (
    input  logic             clk,
    input  logic             rst_n,
    inst_mem_loader_if.slave bus,
    output logic             core_rst_n_o,
    output logic             ld_done_o,
    output logic             err_o
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef LOAD_CHECKSUM_EN
    localparam ld_state_t AFTER_PAYLOAD = CSUM;
`else
    localparam ld_state_t AFTER_PAYLOAD = RUN;
`endif

    ld_state_t   state;
    logic [15:0] len;
    logic [15:0] widx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_acc;
    logic        ld_ready;
    logic        xfer;
    logic        payload_end;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] rom_data;

    // A restart in the same cycle as a valid byte swallows that byte.
    assign xfer        = bus.ld_valid_i && ld_ready && !bus.ld_restart_i;
    assign payload_end = xfer && (((state == LEN1) && ({bus.ld_data_i, len[7:0]} == 16'd0)) ||
                                  ((state == DATA) && (byte_cnt == 2'd3) && ((widx + 16'd1) == len)));
    // Words past the end of the array are counted but never wrap into low memory.
    assign mem_we      = xfer && (state == DATA) && (byte_cnt == 2'd3) &&
                         ({16'd0, widx} < 32'(DEPTH));

`ifdef LOAD_CHECKSUM_EN
    logic [CSUM_W-1:0] csum;
    logic [CSUM_W-1:0] csum_sum;
    logic              csum_ok;
    logic              err_r;

    assign csum_sum = csum + bus.ld_data_i;
    assign csum_ok  = (csum_sum == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum  <= '0;
            err_r <= 1'b0;
        end else if (bus.ld_restart_i) begin
            csum  <= '0;
            err_r <= 1'b0;
        end else if (xfer) begin
            if (state == CSUM) begin
                err_r <= !csum_ok;
            end else begin
                csum <= csum_sum;
            end
        end
    end

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LEN0;
            len          <= '0;
            widx         <= '0;
            byte_cnt     <= '0;
            ld_ready     <= 1'b1;
            core_rst_n_o <= 1'b0;
            ld_done_o    <= 1'b0;
        end else if (bus.ld_restart_i) begin
            state        <= LEN0;
            len          <= '0;
            widx         <= '0;
            byte_cnt     <= '0;
            ld_ready     <= 1'b1;
            core_rst_n_o <= 1'b0;
            ld_done_o    <= 1'b0;
        end else if (xfer) begin
            case (state)
                LEN0: begin
                    len[7:0] <= bus.ld_data_i;
                    state    <= LEN1;
                end
                LEN1: begin
                    len[15:8] <= bus.ld_data_i;
                    state     <= DATA;
                end
                DATA: begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        widx <= widx + 16'd1;
                    end
                end
`ifdef LOAD_CHECKSUM_EN
                CSUM: begin
                    ld_ready <= 1'b0;
                    if (csum_ok) begin
                        state        <= RUN;
                        core_rst_n_o <= 1'b1;
                        ld_done_o    <= 1'b1;
                    end else begin
                        state <= ERR;
                    end
                end
`endif
                default: ;
            endcase
            // Overrides the per-state next state once the length or last word is consumed.
            if (payload_end) begin
                state        <= AFTER_PAYLOAD;
                ld_ready     <= (AFTER_PAYLOAD != RUN);
                core_rst_n_o <= (AFTER_PAYLOAD == RUN);
                ld_done_o    <= (AFTER_PAYLOAD == RUN);
            end
        end
    end

    // Little-endian assembly: the first byte of a word ends up in [7:0].
    always_ff @(posedge clk) begin
        if (xfer && (state == DATA)) begin
            word_acc <= {bus.ld_data_i, word_acc[23:8]};
        end
    end

    inst_mem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (widx[ADDR_W-1:0]),
        .wdata ({bus.ld_data_i, word_acc}),
        .raddr (bus.rom_addr_i[ADDR_W+1:2]),
        .rdata (mem_rdata)
    );

    always_comb begin
        rom_data = mem_rdata;
        if (!bus.rom_ce_i || !core_rst_n_o) begin
            rom_data = '0;
        end else if ((bus.rom_addr_i >> (ADDR_W + 2)) != 32'd0) begin
            rom_data = NOP_INST;
        end
    end

    assign bus.rom_data_o = rom_data;
    assign bus.ld_ready_o = ld_ready;

endmodule
